// File: rtl/bin_stream_if.sv
// bin_stream_if: SRAM read port plus 8-bit AXI-Stream output of the bin reader.
//
// Handshake: a beat transfers on a rising clk edge where m_axis_tvalid and
// m_axis_tready are both high. Once tvalid is raised, it and tdata/tlast/tuser
// hold steady until that transfer happens. tvalid never depends on tready.
// SRAM side: rdata carries the word for addr exactly one cycle after rd_en.
interface bin_stream_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic              rd_en;
  logic [31:0]       rdata;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              m_axis_tuser;

  modport master (
    output addr, rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  rdata, m_axis_tready
  );

  modport slave (
    input  addr, rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output rdata, m_axis_tready
  );
endinterface

// File: rtl/bin_stream_reader.sv
// bin_stream_reader: streams one frame of NUM_BINS bins from the SRAM bin
// buffer (BASE_ADDR upward) as 8-bit AXI-Stream beats. Reads are credit
// limited so a 2-entry FIFO can absorb the 1-cycle SRAM latency at full rate.
// Optional build macro BIN_READER_THRESH_EN: binarize bins against THRESHOLD
// as they are written into the FIFO.
module bin_stream_reader #(
  parameter int NUM_BINS  = 784,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 32,
  parameter int THRESHOLD = 128
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_read,
  output logic           busy,
  output logic           read_done,
  output logic [1:0]     state_dbg,
  bin_stream_if.master   bus
);
  localparam int CNT_W = $clog2(NUM_BINS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] NUM_CNT  = CNT_W'(NUM_BINS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  issue_cnt, beat_cnt, inflight_idx;
  logic              inflight;
  logic [ADDR_W-1:0] addr_q;
  // FIFO entry layout: {tlast, tuser, tdata}
  logic [9:0]        fifo_mem [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_count;
  logic              pop, push, rd_go;
  logic [2:0]        occ;
  logic [7:0]        sat_val, bin_val;
  logic [9:0]        head;

  assign state_dbg = state;
  assign busy      = (state != IDLE);
  assign read_done = (state == DONE);

  // Handshake, credit check and read issue decision
  always_comb begin
    bus.m_axis_tvalid = (fifo_count != 2'd0);
    pop   = bus.m_axis_tvalid & bus.m_axis_tready;
    push  = inflight;
    occ   = 3'(fifo_count) + 3'(inflight);
    rd_go = (state == STREAM) && (issue_cnt < NUM_CNT) && (occ < (3'd2 + 3'(pop)));
    bus.rd_en = rd_go;
    bus.addr  = rd_go ? (ADDR_W'(BASE_ADDR) + ADDR_W'(issue_cnt)) : addr_q;
  end

  // Bin value conversion applied to the returning SRAM word
  always_comb begin
    sat_val = (bus.rdata[31:8] == 24'd0) ? bus.rdata[7:0] : 8'hFF;
`ifdef BIN_READER_THRESH_EN
    bin_val = (int'(sat_val) >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    bin_val = sat_val;
`endif
  end

  // Stream outputs come from the FIFO head; forced to zero when empty
  always_comb begin
    head = fifo_mem[rd_ptr];
    bus.m_axis_tdata = bus.m_axis_tvalid ? head[7:0] : 8'h00;
    bus.m_axis_tuser = bus.m_axis_tvalid & head[8];
    bus.m_axis_tlast = bus.m_axis_tvalid & head[9];
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_read) state_nxt = STREAM;
      STREAM:  if (pop && (beat_cnt == LAST_IDX)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue/beat counters, in-flight tracking and held address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt    <= '0;
      beat_cnt     <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      addr_q       <= '0;
    end else begin
      inflight <= rd_go;
      if (state == IDLE && start_read) begin
        issue_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (rd_go) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   beat_cnt  <= beat_cnt + 1'b1;
      end
      if (rd_go) begin
        inflight_idx <= issue_cnt;
        addr_q       <= bus.addr;
      end
    end
  end

  // 2-entry FIFO; a word read last cycle is written now, tagged by its index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {(inflight_idx == LAST_IDX), (inflight_idx == '0), bin_val};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_bin_stream_reader.sv
// tb_bin_stream_reader: frame-level bench for bin_stream_reader with an SRAM
// model, a queue-based expected-beat model and randomized tready/SRAM data.
module tb_bin_stream_reader;
  localparam int NUM_BINS  = 784;
  localparam int BASE_ADDR = 0;
  localparam int ADDR_W    = 32;
  localparam int THRESHOLD = 128;
  localparam int LIMIT     = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_read = 1'b0;
  logic       busy, read_done;
  logic [1:0] state_dbg;

  bin_stream_if #(.ADDR_W(ADDR_W)) bus ();

  bin_stream_reader #(
    .NUM_BINS(NUM_BINS), .BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk(clk), .reset(reset), .start_read(start_read),
    .busy(busy), .read_done(read_done), .state_dbg(state_dbg), .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  logic [31:0] mem [NUM_BINS];
  logic [7:0]  got [NUM_BINS];
  logic [9:0]  exp_q [$];
  int checks = 0;
  int failures = 0;

  // SRAM model: one-cycle read latency, garbage when not reading
  always @(posedge clk) begin
    int idx;
    idx = int'(bus.addr) - BASE_ADDR;
    if (bus.rd_en && idx >= 0 && idx < NUM_BINS) bus.rdata <= mem[idx];
    else                                         bus.rdata <= $urandom;
  end

  // Reference conversion of one SRAM word to the streamed byte
  function automatic logic [7:0] exp_bin(input logic [31:0] w);
    int v;
    v = (w > 32'd255) ? 255 : int'(w);
`ifdef BIN_READER_THRESH_EN
    v = (v >= THRESHOLD) ? 255 : 0;
`endif
    return 8'(v);
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({bus.rd_en, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, busy, read_done} !== 6'b0 ||
        bus.m_axis_tdata !== 8'h00 || bus.addr !== '0) begin
      failures++;
      $display("FAIL %s: rd_en=%b addr=%0h tvalid=%b tlast=%b tuser=%b tdata=%0h busy=%b done=%b, required all zero",
               name, bus.rd_en, bus.addr, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser,
               bus.m_axis_tdata, busy, read_done);
    end
  endtask

  // Runs one frame; optional extra start pulse at beat restart_at and reset at beat reset_at
  task automatic run_frame(input int ready_pct, input int restart_at, input int reset_at,
                           output int beats, output int first_rd, output int first_valid,
                           output int last_cyc, output int done_cyc, output int done_cnt);
    int issued, cyc;
    bit finished, prev_stall, prev_done, restarted;
    logic [9:0] prev_beat, exp_b, obs;
    exp_q.delete();
    for (int i = 0; i < NUM_BINS; i++)
      exp_q.push_back({(i == NUM_BINS - 1), (i == 0), exp_bin(mem[i])});
    beats = 0; issued = 0; first_rd = -1; first_valid = -1; last_cyc = -1;
    done_cyc = -1; done_cnt = 0; finished = 0; prev_stall = 0; prev_done = 0;
    restarted = 0; prev_beat = '0;
    @(negedge clk);
    start_read = 1'b1;
    for (cyc = 0; cyc < LIMIT && !finished; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start_read = 1'b0;
        if (restart_at >= 0 && beats == restart_at && !restarted) begin
          start_read = 1'b1;
          restarted = 1;
        end
      end
      bus.m_axis_tready = ($urandom_range(0, 99) < ready_pct);
      if (reset_at >= 0 && beats == reset_at) begin
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_frame_outputs");
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
          bus.m_axis_tready = 1'b1;
          #1;
          checks++;
          if (bus.m_axis_tvalid !== 1'b0 || bus.rd_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stale_after_reset: tvalid=%b rd_en=%b busy=%b, required 0 0 0",
                     bus.m_axis_tvalid, bus.rd_en, busy);
          end
          @(negedge clk);
        end
        return;
      end
      #1;
      if (cyc == 0) begin
        checks++;
        if (busy !== 1'b0 || bus.rd_en !== 1'b0) begin
          failures++;
          $display("FAIL start_cycle: busy=%b rd_en=%b, required 0 0", busy, bus.rd_en);
        end
      end
      if (bus.rd_en) begin
        checks++;
        if (bus.addr !== ADDR_W'(BASE_ADDR + issued)) begin
          failures++;
          $display("FAIL read_addr: got %0h, required %0h", bus.addr, BASE_ADDR + issued);
        end
        if (first_rd < 0) first_rd = cyc;
        issued++;
      end
      if (prev_stall) begin
        checks++;
        obs = {bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata};
        if (bus.m_axis_tvalid !== 1'b1 || obs !== prev_beat) begin
          failures++;
          $display("FAIL stall_hold: tvalid=%b beat=%0h, required 1 %0h", bus.m_axis_tvalid, obs, prev_beat);
        end
      end
      if (bus.m_axis_tvalid && first_valid < 0) first_valid = cyc;
      prev_beat  = {bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata};
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat: got beat %0h, required no beat", prev_beat);
        end else begin
          exp_b = exp_q.pop_front();
          if (prev_beat !== exp_b) begin
            failures++;
            $display("FAIL beat_%0d {tlast,tuser,tdata}: got %0h, required %0h", beats, prev_beat, exp_b);
          end
        end
        if (beats < NUM_BINS) got[beats] = bus.m_axis_tdata;
        beats++;
        last_cyc = cyc;
      end
      checks++;
      if (issued - beats > 2) begin
        failures++;
        $display("FAIL occupancy: reads outstanding plus buffered %0d, required <= 2", issued - beats);
      end
      if (prev_done) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_after_done: got %b, required 0", busy);
        end
      end
      if (read_done) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_with_done: got %b, required 1", busy);
        end
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      prev_done = read_done;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
    end
    checks++;
    if (!finished || exp_q.size() != 0) begin
      failures++;
      $display("FAIL frame_complete: finished=%0d beats_missing=%0d, required 1 0", finished, exp_q.size());
    end
    bus.m_axis_tready = 1'b0;
  endtask

  task automatic expect_int(input string name, input int got_v, input int req_v);
    checks++;
    if (got_v !== req_v) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got_v, req_v);
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs("reset_asserted");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_full_rate();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 32'(i & 8'hFF);
    run_frame(100, -1, -1, b, fr, fv, lc, dc, dn);
    expect_int("full_beats", b, NUM_BINS);
    expect_int("full_first_rd_cycle", fr, 1);
    expect_int("full_first_tvalid_cycle", fv, 3);
    expect_int("full_last_beat_cycle", lc, 3 + NUM_BINS - 1);
    expect_int("full_done_cycle", dc, 3 + NUM_BINS);
    expect_int("full_done_count", dn, 1);
    expect_int("full_beat_255", got[255], 255);
    expect_int("full_beat_256", got[256], 0);
  endtask

  task automatic test_random_ready();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
    run_frame(50, -1, -1, b, fr, fv, lc, dc, dn);
    expect_int("rand_beats", b, NUM_BINS);
    expect_int("rand_done_count", dn, 1);
  endtask

  task automatic test_saturate();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 32'(i & 8'hFF);
    mem[5] = 32'h0000_01F4;
    mem[6] = 32'h0000_00C8;
    run_frame(100, -1, -1, b, fr, fv, lc, dc, dn);
`ifdef BIN_READER_THRESH_EN
    expect_int("sat_beat5", got[5], 8'hFF);
    expect_int("sat_beat6", got[6], 8'hFF);
`else
    expect_int("sat_beat5", got[5], 8'hFF);
    expect_int("sat_beat6", got[6], 8'hC8);
`endif
  endtask

  task automatic test_restart_ignored();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = $urandom_range(0, 511);
    run_frame(100, 100, -1, b, fr, fv, lc, dc, dn);
    expect_int("restart_beats", b, NUM_BINS);
    expect_int("restart_done_count", dn, 1);
  endtask

  task automatic test_reset_mid_frame();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 32'(i & 8'hFF);
    run_frame(100, -1, 300, b, fr, fv, lc, dc, dn);
    expect_int("reset_beats_before", b, 300);
    run_frame(100, -1, -1, b, fr, fv, lc, dc, dn);
    expect_int("post_reset_beats", b, NUM_BINS);
    expect_int("post_reset_first_tvalid", fv, 3);
    expect_int("post_reset_beat0", got[0], 0);
  endtask

  task automatic test_threshold();
    int b, fr, fv, lc, dc, dn;
    for (int i = 0; i < NUM_BINS; i++) mem[i] = 32'($urandom_range(0, 300));
    mem[0] = 32'd127;
    mem[1] = 32'd128;
    mem[2] = 32'h300;
    run_frame(100, -1, -1, b, fr, fv, lc, dc, dn);
`ifdef BIN_READER_THRESH_EN
    expect_int("thresh_127", got[0], 8'h00);
    expect_int("thresh_128", got[1], 8'hFF);
    expect_int("thresh_300h", got[2], 8'hFF);
`else
    expect_int("plain_127", got[0], 8'h7F);
    expect_int("plain_128", got[1], 8'h80);
    expect_int("plain_300h", got[2], 8'hFF);
`endif
  endtask

  initial begin
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_full_rate();
    test_random_ready();
    test_saturate();
    test_restart_ignored();
    test_reset_mid_frame();
    test_threshold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bin_stream_reader.md
Name: bin_stream_reader

Overview: Reads the 28x28 binned-grayscale frame from the SRAM bin buffer, starting at BASE_ADDR, once the binning stage has filled it. Streams the bins out in address order as an 8-bit AXI-Stream master. The consumer is the downstream classifier or CPU DMA. This block is the read side of the SRAM buffer that the resizer writes.

Parameters:
NUM_BINS, 784, bins per frame (28*28); last bin address is BASE_ADDR+NUM_BINS-1
BASE_ADDR, 0, SRAM word address of bin 0
ADDR_W, 32, SRAM address width
THRESHOLD, 128, binarization threshold (used only with BIN_READER_THRESH_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start_read  in  1  single-cycle pulse that starts streaming one frame; honoured only in IDLE
addr  out  ADDR_W  SRAM word address
rd_en  out  1  SRAM read strobe; rdata is valid exactly 1 cycle after rd_en
rdata  in  32  SRAM read data; bin value in low bits
m_axis_tdata  out  8  bin value
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  consumer ready
m_axis_tlast  out  1  high on bin NUM_BINS-1
m_axis_tuser  out  1  high on bin 0 (start of frame)
busy  out  1  high from the cycle after accepted start_read until read_done
read_done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (async assert, removal synced to clk): state IDLE; addr=0; rd_en=0; m_axis_tvalid/tlast/tuser=0; tdata=0; busy=0; read_done=0. Internal FIFO is emptied and counters are cleared. rdata returning after a reset mid-frame is discarded.
- States:
  - IDLE: on start_read go to STREAM; issue counter=0; beat counter=0.
  - STREAM: issue reads and drain the FIFO. When a beat is accepted with beat counter=NUM_BINS-1, go to DONE.
  - DONE: assert read_done for 1 cycle, then go to IDLE.
- start_read is ignored outside IDLE and does not restart the frame.
- Reads:
  - rd_en=1 with addr=BASE_ADDR+issue_cnt when all hold: state=STREAM, issue_cnt<NUM_BINS, and (fifo_count+inflight-pop_this_cycle)<2.
  - inflight is 1 if rd_en was high the previous cycle.
  - addr holds its last value while rd_en=0.
- Buffering:
  - 2-entry FIFO; the returning rdata is written into it on the cycle after rd_en.
  - This credit rule sustains 1 beat/cycle with tready held high and never overflows under any tready pattern.
- Output:
  - m_axis_tvalid = FIFO non-empty; tdata, tlast and tuser come from the FIFO head.
  - Handshake = tvalid & tready. tdata/tlast/tuser are stable while tvalid=1 and tready=0, and tvalid never drops without a handshake.
- Latency: with tready=1, start_read at cycle 0 gives rd_en at cycle 1 and the first beat tvalid at cycle 3. The last beat is at cycle 3+NUM_BINS-1, and read_done follows 1 cycle after the last handshake.
- Width rule: bin value = rdata[7:0] if rdata[31:8]==0, else 8'hFF (saturate).
- busy=1 in STREAM and DONE.
- Simultaneous FIFO push and pop: count unchanged and order preserved.
- Data order equals SRAM address order; no bins are dropped or duplicated.

Optional Feature:
Macro BIN_READER_THRESH_EN.
- Defined: tdata = (saturated value >= THRESHOLD) ? 8'hFF : 8'h00. The threshold is applied at FIFO write, with no added latency.
- Undefined: tdata = saturated value; the THRESHOLD parameter is unused.
- All other timing is identical in both builds.

Test Plan:
- SRAM model with mem[i]=i&0xFF, tready=1, pulse start_read -> 784 beats at 1/cycle, tdata=0..255 repeating. tuser only on beat 0, tlast only on beat 783, read_done 1 cycle after beat 783, first tvalid 3 cycles after start.
- Same frame with tready as a random 50% pattern -> 784 beats in order, no drop or duplicate. tdata held stable while stalled, and at most 2 reads outstanding plus buffered at any time.
- mem[5]=0x000001F4, mem[6]=0x000000C8 -> beat 5 tdata=0xFF, beat 6 tdata=0xC8.
- Pulse start_read again at beat 100 -> ignored; frame completes with exactly 784 beats and one read_done.
- Assert reset at beat 300 while rd_en is in flight -> all outputs 0 the same cycle, no stale beat after release. A new start_read then produces a full 784-beat frame beginning at bin 0.
- With BIN_READER_THRESH_EN defined and THRESHOLD=128: mem values 127, 128, 0x300 -> tdata 0x00, 0xFF, 0xFF.
